async_uart: RTL and testbench
=============================

ASYNC_UART -- requirements
Module: async_uart

Interface
REQ-001 Parameter ClkFrequency, default 10000000, input clock frequency in Hz.
REQ-002 Parameter Baud, default 19200, line bit rate; bit period DIV = round(ClkFrequency/Baud), 521 at defaults.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 RxD  input  1  serial receive line, idle high, asynchronous to clk.
REQ-006 RxD_data_ready  output  1  one-cycle pulse, new received byte valid.
REQ-007 RxD_data  output  8  last good received byte, held until the next good byte.
REQ-008 TxD  output  1  serial transmit line, idle high.
REQ-009 TxD_start  input  1  transmit request, sampled each cycle.
REQ-010 TxD_data  input  8  byte to send, captured with an accepted TxD_start.
REQ-011 TxD_busy  output  1  high while a frame is being sent.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, no parity.
REQ-013 TX: TxD_start=1 with TxD_busy=0 SHALL capture TxD_data; TxD_busy=1 and TxD=0 from the next cycle.
REQ-014 TX: each bit SHALL last exactly DIV cycles; frame is 10*DIV cycles; TxD_busy SHALL drop on the cycle the stop bit ends.
REQ-015 TX: TxD_start while TxD_busy=1 SHALL be ignored; the in-flight byte is unaffected by TxD_data changes.
REQ-016 TX: a new TxD_start on the first cycle TxD_busy=0 SHALL be accepted (back-to-back frames, no gap).
REQ-017 RX: RxD SHALL pass a 2-flop synchronizer before any use.
REQ-018 RX states IDLE, START, DATA, STOP; IDLE->START on synchronized falling edge.
REQ-019 RX START: after DIV/2 cycles, RxD still 0 -> DATA; else back to IDLE (glitch rejected).
REQ-020 RX DATA: sample 8 bits, each DIV cycles after the previous sample point (mid-bit), shift in LSB first.
REQ-021 RX STOP: sample DIV cycles after bit 7; 1 -> update RxD_data and pulse RxD_data_ready that cycle, go IDLE; 0 -> framing error, RxD_data unchanged, no ready pulse, wait for RxD=1 then IDLE.
REQ-022 RX and TX SHALL operate fully independently and concurrently.
REQ-023 Counters SHALL be wide enough for DIV without wrap; DIV<2 is unsupported.

Reset
REQ-024 rst_n=0 SHALL immediately force TxD=1, TxD_busy=0, RxD_data_ready=0, RxD_data=8'h00, both state machines to idle, counters and synchronizer to idle (1) values.
REQ-025 Reset mid-frame SHALL abort the frame; no partial byte reported, TX line returns high without completing.
REQ-026 After rst_n rises, the first TxD_start is accepted in the first cycle; RX arms on the next falling edge.

Configuration
REQ-027 Macro ASYNC_UART_FRAME_ERR_EN defined: extra output RxD_frame_err (1 bit) SHALL pulse one cycle at the stop-bit sample when stop bit is 0; reset value 0.
REQ-028 Macro undefined: port RxD_frame_err SHALL not exist; bad frames are silently dropped per REQ-021.

Verification
REQ-029 TxD_start with TxD_data=0x55, defaults -> TxD 0,1,0,1,0,1,0,1,0,1 each 521 cycles; TxD_busy high 5210 cycles.
REQ-030 Loopback TxD->RxD, send 0x02,0x03,0x06 back-to-back -> three RxD_data_ready pulses with RxD_data 0x02,0x03,0x06.
REQ-031 RxD low 100 cycles then high -> no RxD_data_ready, RX back to IDLE, next frame 0xDA received correctly.
REQ-032 Frame 0xA5 with stop bit 0 -> no ready pulse, RxD_data keeps prior value; RxD_frame_err pulses once only with ASYNC_UART_FRAME_ERR_EN.
REQ-033 Second TxD_start (0x81) mid-frame of 0x33 -> ignored; only 0x33 on TxD.
REQ-034 rst_n low during bit 4 of TX and RX frames -> TxD=1, TxD_busy=0, no ready pulse; subsequent 0xC2 transfer correct.

Source files
------------

// File: rtl/async_uart.sv
`timescale 1ns/1ps
// async_uart: 8N1 UART transmitter and receiver on one clock, bit period round(ClkFrequency/Baud).
// Define ASYNC_UART_FRAME_ERR_EN to add the RxD_frame_err stop-bit error pulse output.
module async_uart #(
  parameter int ClkFrequency = 10000000,
  parameter int Baud         = 19200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data,
  output logic       TxD,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD_busy
`ifdef ASYNC_UART_FRAME_ERR_EN
  ,
  output logic       RxD_frame_err
`endif
);

  localparam int DIV = (ClkFrequency + Baud / 2) / Baud;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          r_tx_busy;
  logic          r_txd;
  logic [7:0]    r_tx_shift;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic          w_tx_accept;
  logic          w_tx_tick;

  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  logic [1:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_brk;
  logic [7:0]    r_rx_data;
  logic          r_rx_ready;
  logic          w_rx_fall;
  logic          w_rx_tick;
  logic          w_rx_half;

  assign w_tx_accept = TxD_start & ~r_tx_busy;
  assign w_tx_tick   = (r_tx_cnt == DIV_LAST);

  // Transmit shifter; r_tx_bit is the frame slot on the line (0 start, 1-8 data, 9 stop).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_busy  <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_shift <= 8'h00;
      r_tx_cnt   <= CNT_ZERO;
      r_tx_bit   <= 4'd0;
    end else if (w_tx_accept) begin
      r_tx_busy  <= 1'b1;
      r_txd      <= 1'b0;
      r_tx_shift <= TxD_data;
      r_tx_cnt   <= CNT_ZERO;
      r_tx_bit   <= 4'd0;
    end else if (r_tx_busy) begin
      if (w_tx_tick) begin
        r_tx_cnt <= CNT_ZERO;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_txd     <= 1'b1;
        end else begin
          r_tx_bit <= r_tx_bit + 4'd1;
          if (r_tx_bit == 4'd8) begin
            r_txd <= 1'b1;
          end else begin
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + CNT_ONE;
      end
    end
  end

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RxD;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;
  assign w_rx_tick = (r_rx_cnt == DIV_LAST);
  assign w_rx_half = (r_rx_cnt == HALF_LAST);

  // Receive FSM; r_rx_brk holds STOP after a framing error until the line returns high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= CNT_ZERO;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_brk   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_ready <= 1'b0;
    end else begin
      r_rx_ready <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= CNT_ZERO;
          r_rx_brk <= 1'b0;
          if (w_rx_fall) begin
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_rx_half) begin
            r_rx_cnt   <= CNT_ZERO;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= CNT_ZERO;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (r_rx_brk) begin
            if (r_rx_sync) begin
              r_rx_brk   <= 1'b0;
              r_rx_state <= RX_IDLE;
            end
          end else if (w_rx_tick) begin
            r_rx_cnt <= CNT_ZERO;
            if (r_rx_sync) begin
              r_rx_data  <= r_rx_shift;
              r_rx_ready <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_brk <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

`ifdef ASYNC_UART_FRAME_ERR_EN
  logic r_rx_ferr;

  // One-cycle pulse when the stop bit is sampled low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ferr <= 1'b0;
    end else begin
      r_rx_ferr <= (r_rx_state == RX_STOP) & ~r_rx_brk & w_rx_tick & ~r_rx_sync;
    end
  end

  assign RxD_frame_err = r_rx_ferr;
`endif

  assign TxD            = r_txd;
  assign TxD_busy       = r_tx_busy;
  assign RxD_data       = r_rx_data;
  assign RxD_data_ready = r_rx_ready;

endmodule

// File: tb/tb_async_uart.sv
`timescale 1ns/1ps
// Directed bench for async_uart at default parameters (bit period 521 cycles).
module tb_async_uart;

  localparam int DIV = 521;

  typedef struct {
    logic [7:0] tx;
    logic [9:0] frame;
    logic [7:0] rx;
    int         inject;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       TxD;
  logic       TxD_start;
  logic [7:0] TxD_data;
  logic       TxD_busy;
  logic       RxD_data_ready;
  logic [7:0] RxD_data;
  logic       loop_en;
  logic       rxd_drv;
  logic       rxd_line;
`ifdef ASYNC_UART_FRAME_ERR_EN
  logic       rxd_ferr;
  int         ferr_cnt;
`endif

  int         n_tests;
  int         n_fail;
  int         ready_cnt;
  logic [7:0] last_rx;
  vec_t       vecs [7];

  assign rxd_line = loop_en ? TxD : rxd_drv;

  async_uart dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .RxD            (rxd_line),
    .RxD_data_ready (RxD_data_ready),
    .RxD_data       (RxD_data),
    .TxD            (TxD),
    .TxD_start      (TxD_start),
    .TxD_data       (TxD_data),
    .TxD_busy       (TxD_busy)
`ifdef ASYNC_UART_FRAME_ERR_EN
    ,
    .RxD_frame_err  (rxd_ferr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (RxD_data_ready === 1'b1) begin
      ready_cnt <= ready_cnt + 1;
      last_rx   <= RxD_data;
    end
  end

`ifdef ASYNC_UART_FRAME_ERR_EN
  always @(negedge clk) begin
    if (rxd_ferr === 1'b1) begin
      ferr_cnt <= ferr_cnt + 1;
    end
  end
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Start a frame, check every line cycle against the expected frame, then busy/idle and RX result.
  task automatic send_frame(input logic [7:0] d, input logic [9:0] exp_frame,
                            input logic [7:0] exp_rx, input int inject_at, input string nm);
    int line_err;
    int busy_err;
    int rc0;
    line_err = 0;
    busy_err = 0;
    rc0      = ready_cnt;
    @(negedge clk);
    TxD_start = 1'b1;
    TxD_data  = d;
    @(posedge clk); #1;
    TxD_start = 1'b0;
    TxD_data  = ~d;
    for (int c = 0; c < 10 * DIV; c++) begin
      if (c == inject_at) begin
        TxD_start = 1'b1;
        TxD_data  = 8'h81;
      end
      if (c == inject_at + 40) TxD_start = 1'b0;
      if (TxD !== exp_frame[c / DIV]) line_err++;
      if (TxD_busy !== 1'b1) busy_err++;
      @(posedge clk); #1;
    end
    check({nm, "_line"}, 32'(line_err), 32'd0);
    check({nm, "_busy_len"}, 32'(busy_err), 32'd0);
    check({nm, "_busy_drop"}, {31'd0, TxD_busy}, 32'd0);
    check({nm, "_idle_line"}, {31'd0, TxD}, 32'd1);
    check({nm, "_ready_cnt"}, 32'(ready_cnt - rc0), 32'd1);
    check({nm, "_rx_byte"}, {24'd0, last_rx}, {24'd0, exp_rx});
  endtask

  // Drive one frame on RxD directly, followed by one idle bit period.
  task automatic rx_send(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (DIV) @(posedge clk);
    end
    rxd_drv = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  initial begin
    int rc0;
    int err;
    n_tests   = 0;
    n_fail    = 0;
    ready_cnt = 0;
    last_rx   = 8'h00;
`ifdef ASYNC_UART_FRAME_ERR_EN
    ferr_cnt  = 0;
`endif
    vecs[0] = '{8'h55, 10'h2AA, 8'h55, -1};
    vecs[1] = '{8'h02, 10'h204, 8'h02, -1};
    vecs[2] = '{8'h03, 10'h206, 8'h03, -1};
    vecs[3] = '{8'h06, 10'h20C, 8'h06, -1};
    vecs[4] = '{8'hFF, 10'h3FE, 8'hFF, -1};
    vecs[5] = '{8'h00, 10'h200, 8'h00, -1};
    vecs[6] = '{8'h33, 10'h266, 8'h33, 2000};

    rst_n     = 1'b0;
    TxD_start = 1'b0;
    TxD_data  = 8'h00;
    loop_en   = 1'b0;
    rxd_drv   = 1'b1;
    #23;
    check("rst_txd", {31'd0, TxD}, 32'd1);
    check("rst_busy", {31'd0, TxD_busy}, 32'd0);
    check("rst_ready", {31'd0, RxD_data_ready}, 32'd0);
    check("rst_data", {24'd0, RxD_data}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    loop_en = 1'b1;

    // Back-to-back loopback frames; the last one carries an ignored mid-frame start of 0x81.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].tx, vecs[i].frame, vecs[i].rx, vecs[i].inject, $sformatf("v%0d", i));
    end
    err = 0;
    for (int c = 0; c < 30; c++) begin
      if (TxD_busy !== 1'b0 || TxD !== 1'b1) err++;
      @(posedge clk); #1;
    end
    check("ignored_start_no_frame", 32'(err), 32'd0);

    // Short low glitch must not produce a byte; next real frame still decodes.
    loop_en = 1'b0;
    rc0     = ready_cnt;
    rxd_drv = 1'b0;
    repeat (100) @(posedge clk);
    rxd_drv = 1'b1;
    repeat (11 * DIV) @(posedge clk);
    #1;
    check("glitch_no_ready", 32'(ready_cnt - rc0), 32'd0);
    rx_send(8'hDA, 1'b1);
    check("da_ready_cnt", 32'(ready_cnt - rc0), 32'd1);
    check("da_data", {24'd0, RxD_data}, 32'hDA);

    // Framing error: no pulse, data held, optional error pulse, then recovery.
    rc0 = ready_cnt;
    rx_send(8'hA5, 1'b0);
    check("ferr_no_ready", 32'(ready_cnt - rc0), 32'd0);
    check("ferr_data_held", {24'd0, RxD_data}, 32'hDA);
`ifdef ASYNC_UART_FRAME_ERR_EN
    check("ferr_pulse_cnt", 32'(ferr_cnt), 32'd1);
`endif
    rx_send(8'h3C, 1'b1);
    check("recover_ready_cnt", 32'(ready_cnt - rc0), 32'd1);
    check("recover_data", {24'd0, RxD_data}, 32'h3C);

    // Reset in the middle of data bit 4 of a looped-back 0xE7 frame.
    loop_en = 1'b1;
    rc0     = ready_cnt;
    @(negedge clk);
    TxD_start = 1'b1;
    TxD_data  = 8'hE7;
    @(posedge clk); #1;
    TxD_start = 1'b0;
    repeat (5 * DIV + DIV / 2) @(posedge clk);
    #3;
    check("pre_rst_txd_low", {31'd0, TxD}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", {31'd0, TxD}, 32'd1);
    check("midrst_busy", {31'd0, TxD_busy}, 32'd0);
    check("midrst_data", {24'd0, RxD_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    err = 0;
    for (int c = 0; c < 10 * DIV; c++) begin
      @(posedge clk); #1;
      if (TxD !== 1'b1 || TxD_busy !== 1'b0) err++;
    end
    check("postrst_idle", 32'(err), 32'd0);
    check("postrst_no_ready", 32'(ready_cnt - rc0), 32'd0);
    send_frame(8'hC2, 10'h384, 8'hC2, -1, "c2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
